// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display write arbiter.
// Holds the arbiter state encoding, the requester count and default timeout,
// the Wishbone write payload layout, and a small index-to-one-hot helper.
package hex_display_pkg;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned DAT_W       = 16;
    localparam int unsigned SEL_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Write payload presented to the display slave.
    typedef struct packed {
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } wb_wr_t;

    function automatic logic [NREQ_DEF-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NREQ_DEF'(1) << idx;
    endfunction

endpackage

// File: rtl/hex_display_rr_pick.sv
// Round-robin winner selection for the hex display arbiter.
// Searches req_i starting at ptr_i and wrapping (ptr, ptr+1, ... mod NREQ).
// Ports:
//   req_i   - request vector
//   ptr_i   - index given first priority
//   grant_o - one-hot winner (zero when nothing requests)
//   index_o - binary winner index
//   any_o   - at least one request present
module hex_display_rr_pick
    import hex_display_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    // Index arithmetic wraps naturally because NREQ is a power of two.
    always_comb begin : rr_search
        logic [IDX_W-1:0] cand;
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!any_o && req_i[cand]) begin
                any_o   = 1'b1;
                index_o = cand;
                grant_o = NREQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/hex_display_arb.sv
// Arbitrates display writes from NREQ requesters onto one Wishbone master.
// One write at a time: IDLE picks a round-robin winner and latches its data,
// BUS holds the Wishbone cycle until ack or timeout, GAP pulses gnt/err for
// one cycle while swallowing the slave's trailing registered ack.
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   req_i, req_dat_i  - per-requester request level and 16-bit display value
//   gnt_o, err_o      - one-cycle one-hot completion / timeout pulses
//   busy_o            - arbiter not idle
//   wbm_*             - Wishbone master write port to the display slave
module hex_display_arb
    import hex_display_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*DAT_W-1:0] req_dat_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       err_o,
    output logic                  busy_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DAT_W-1:0]      wbm_dat_o,
    output logic [SEL_W-1:0]      wbm_sel_o,
    input  logic                  wbm_ack_i
);

    // Counter holds BUS cycles already spent without ack (0 .. TIMEOUT-1).
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic             busy_q, busy_d;
    logic             cyc_q, cyc_d;
    wb_wr_t           wr_q, wr_d;

    logic [NREQ-1:0]             pick_grant;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_any;
    logic [DAT_W-1:0]            pick_dat;
    logic [NREQ-1:0][DAT_W-1:0]  req_dat_w;
    logic                        timeout_hit;

    assign req_dat_w = req_dat_i;

    hex_display_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .index_o (pick_idx),
        .any_o   (pick_any)
    );

    // One-hot AND-OR mux of the winner's display value.
    always_comb begin : dat_mux
        pick_dat = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pick_dat = pick_dat | (req_dat_w[k] & {DAT_W{pick_grant[k]}});
        end
    end

    // This BUS cycle is the TIMEOUT-th one without an ack.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over timeout.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i || timeout_hit) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin : out_next
        ptr_d  = ptr_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        gnt_d  = '0;
        err_d  = '0;
        cyc_d  = 1'b0;
        wr_d   = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_d     = pick_idx;
                    cnt_d     = '0;
                    cyc_d     = 1'b1;
                    wr_d.dat  = pick_dat;
                    wr_d.sel  = '1;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    gnt_d = idx_to_onehot(idx_q);
                    ptr_d = idx_q + IDX_W'(1);
                end else if (timeout_hit) begin
                    err_d = idx_to_onehot(idx_q);
                    ptr_d = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    cyc_d = 1'b1;
                    wr_d  = wr_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            gnt_q  <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            cyc_q  <= 1'b0;
            wr_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            gnt_q  <= gnt_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            cyc_q  <= cyc_d;
            wr_q   <= wr_d;
        end
    end

    // Cycle, strobe and write enable always move together for this slave.
    assign gnt_o     = gnt_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_dat_o = wr_q.dat;
    assign wbm_sel_o = wr_q.sel;

endmodule

// File: tb/tb_hex_display_arb.sv
// Bench for hex_display_arb: directed scenarios followed by random traffic.
// A transaction-level model expands each arbitration into its expected
// per-cycle output sequence; outputs are compared every cycle on the falling
// edge, and logged values are also checked against hand-computed literals.
module tb_hex_display_arb;

    localparam int TMO   = 15;
    localparam int NCYC  = 3000;
    localparam int NEVER = TMO + 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_dat = '0;
    logic        ack = 1'b0;
    logic [3:0]  gnt, err;
    logic        busy, cyc, stb, we;
    logic [15:0] wdat;
    logic [1:0]  sel;

    hex_display_arb #(
        .NREQ    (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .req_dat_i (req_dat),
        .gnt_o     (gnt),
        .err_o     (err),
        .busy_o    (busy),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_dat_o (wdat),
        .wbm_sel_o (sel),
        .wbm_ack_i (ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        cyc;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [3:0]  gnt;
        logic [3:0]  err;
        logic        ack;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   plan_l = 2;
    bit   plan_trail = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_c = 0;
    logic [3:0] rnd_req = '0;

    logic [3:0]  lg_gnt  [NCYC];
    logic [3:0]  lg_err  [NCYC];
    logic        lg_stb  [NCYC];
    logic        lg_busy [NCYC];
    logic [15:0] lg_dat  [NCYC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cur_c, act, exp);
        end
    endtask

    // Expand one arbitration (sampled now) into its expected cycle sequence.
    task automatic build_xfer();
        int    w;
        bit    granted;
        int    blen;
        logic [15:0] d;
        exp_t  e;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (w < 0 && req[j]) w = j;
        end
        d       = req_dat[16*w +: 16];
        granted = (plan_l <= TMO);
        blen    = granted ? plan_l : TMO;
        for (int j = 1; j <= blen; j++) begin
            e = '{busy: 1'b1, cyc: 1'b1, dat: d, sel: 2'b11, gnt: 4'h0, err: 4'h0,
                  ack: (j == plan_l)};
            q.push_back(e);
        end
        e = '{busy: 1'b1, cyc: 1'b0, dat: 16'h0, sel: 2'b00,
              gnt: granted ? 4'(1 << w) : 4'h0,
              err: granted ? 4'h0 : 4'(1 << w),
              ack: plan_trail};
        q.push_back(e);
        m_ptr = (w + 1) % 4;
    endtask

    task automatic pick_random_plan();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5)      plan_l = 2;
        else if (r == 6) plan_l = 1;
        else if (r == 7) plan_l = $urandom_range(3, 14);
        else if (r == 8) plan_l = TMO;
        else             plan_l = NEVER;
        plan_trail = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_stim(input int c);
        req_dat    = {$urandom, $urandom};
        plan_l     = 2;
        plan_trail = 1'b0;
        req        = 4'h0;
        if (c >= 5 && c <= 21) begin
            req = 4'b1111;
        end else if (c >= 30 && c <= 32) begin
            req = 4'b0100;
            if (c == 30) req_dat[47:32] = 16'h1234;
        end else if (c >= 40 && c <= 55) begin
            req    = 4'b0001;
            plan_l = NEVER;
        end else if (c >= 60 && c <= 76) begin
            req        = 4'b1011;
            plan_l     = TMO;
            plan_trail = 1'b1;
        end else if (c >= 80 && c <= 83) begin
            req    = 4'b1111;
            plan_l = (c < 83) ? NEVER : 2;
        end else if (c >= 100 && c < NCYC - 40) begin
            for (int b = 0; b < 4; b++) begin
                if (rnd_req[b]) begin
                    if ($urandom_range(0, 7) == 0) rnd_req[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rnd_req[b] = 1'b1;
                end
            end
            req = rnd_req;
            pick_random_plan();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_cyc",  32'(cyc),  32'h0);
        chk("rst_stb",  32'(stb),  32'h0);
        chk("rst_we",   32'(we),   32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dat",  32'(wdat), 32'h0);
        chk("rst_sel",  32'(sel),  32'h0);
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_err",  32'(err),  32'h0);
    endtask

    initial begin
        exp_t e;
        bit   idle_now;
        bit   inject;
        int   npulse;
        #1;
        check_reset_outputs();

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cur_c = c;
            if (c >= 2) rst = 1'b0;

            idle_now = (q.size() == 0);
            if (idle_now) e = '0;
            else          e = q.pop_front();

            lg_gnt[c]  = gnt;
            lg_err[c]  = err;
            lg_stb[c]  = stb;
            lg_busy[c] = busy;
            lg_dat[c]  = wdat;

            chk("busy", 32'(busy), 32'(e.busy));
            chk("cyc",  32'(cyc),  32'(e.cyc));
            chk("stb",  32'(stb),  32'(e.cyc));
            chk("we",   32'(we),   32'(e.cyc));
            chk("dat",  32'(wdat), 32'(e.dat));
            chk("sel",  32'(sel),  32'(e.sel));
            chk("gnt",  32'(gnt),  32'(e.gnt));
            chk("err",  32'(err),  32'(e.err));

            ack = e.ack;
            drive_stim(c);

            inject = (c == 82) ||
                     (c >= 100 && c < NCYC - 40 && $urandom_range(0, 249) == 0);

            if (inject) begin
                #2 rst = 1'b1;
                #1;
                check_reset_outputs();
                q.delete();
                m_ptr = 0;
                ack   = 1'b0;
            end else if (!rst && idle_now && req != 4'h0) begin
                build_xfer();
            end
        end

        cur_c = NCYC;
        // Four continuous requesters from ptr 0: grants 0,1,2,3,0, 4 cycles apart.
        chk("rr_g0", 32'(lg_gnt[8]),  32'h1);
        chk("rr_g1", 32'(lg_gnt[12]), 32'h2);
        chk("rr_g2", 32'(lg_gnt[16]), 32'h4);
        chk("rr_g3", 32'(lg_gnt[20]), 32'h8);
        chk("rr_g4", 32'(lg_gnt[24]), 32'h1);
        npulse = 0;
        for (int c = 5; c < 28; c++) if (lg_gnt[c] != 4'h0) npulse++;
        chk("rr_pulses", 32'(npulse), 32'd5);

        // Single request, ack latency 1.
        chk("one_stb",    32'(lg_stb[31]),  32'h1);
        chk("one_dat",    32'(lg_dat[31]),  32'h1234);
        chk("one_hold",   32'(lg_dat[32]),  32'h1234);
        chk("one_gnt",    32'(lg_gnt[33]),  32'h4);
        chk("one_gnt_pre", 32'(lg_gnt[32]), 32'h0);
        chk("one_idle",   32'(lg_busy[34]), 32'h0);

        // No ack: 15 BUS cycles then err to requester 0.
        npulse = 0;
        for (int c = 40; c < 58; c++) if (lg_stb[c]) npulse++;
        chk("tmo_len",   32'(npulse),     32'd15);
        chk("tmo_err",   32'(lg_err[56]), 32'h1);
        chk("tmo_gnt",   32'(lg_gnt[56]), 32'h0);
        chk("tmo_idle",  32'(lg_busy[57]), 32'h0);

        // Ack on the TIMEOUT-th cycle, trailing ack through GAP.
        chk("late_gnt",  32'(lg_gnt[76]), 32'h2);
        chk("late_err",  32'(lg_err[76]), 32'h0);
        chk("trail_stb", 32'(lg_stb[77]), 32'h0);
        chk("trail_gnt", 32'(lg_gnt[77]), 32'h0);

        // Reset in the second BUS cycle, then restart from requester 0.
        chk("abort_stb", 32'(lg_stb[82]), 32'h1);
        chk("abort_gnt", 32'(lg_gnt[83]), 32'h0);
        chk("abort_err", 32'(lg_err[83]), 32'h0);
        chk("post_rst",  32'(lg_gnt[86]), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_arb.md
HEX_DISPLAY_ARB -- requirements
Module: hex_display_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requester ports (fixed at 4 in this revision).
REQ-002 Parameter TIMEOUT, default 15: maximum BUS-state cycles to wait for wbm_ack_i before abort.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 req_i  in  4  per-requester write request, level; held by requester until its gnt_o or err_o pulse.
REQ-006 req_dat_i  in  64  requester k display value at bits [16k+15:16k].
REQ-007 gnt_o  out  4  one-hot, one-cycle pulse: requester k's write acknowledged.
REQ-008 err_o  out  4  one-hot, one-cycle pulse: requester k's write timed out.
REQ-009 busy_o  out  1  high whenever state is not IDLE.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master cycle/strobe/write.
REQ-011 wbm_dat_o  out  16  write data to display slave; wbm_sel_o  out  2  byte selects.
REQ-012 wbm_ack_i  in  1  Wishbone acknowledge from display slave.

Function
REQ-013 FSM states SHALL be IDLE, BUS, GAP; all Wishbone outputs, gnt_o, err_o registered.
REQ-014 IDLE: if any req_i bit set, pick winner by round-robin from pointer ptr (search ptr, ptr+1, ... mod 4), latch index and req_dat_i slice, enter BUS; else stay.
REQ-015 BUS: wbm_cyc_o = wbm_stb_o = wbm_we_o = 1, wbm_sel_o = 2'b11, wbm_dat_o = latched value; first BUS cycle follows the IDLE sampling edge directly.
REQ-016 BUS with wbm_ack_i = 1: next edge enters GAP, drops cyc/stb/we, pulses gnt_o[winner] during the GAP cycle.
REQ-017 BUS timeout counter starts at 0 on BUS entry, increments each BUS cycle without ack; on reaching TIMEOUT, enter GAP with err_o[winner] pulsed instead of gnt_o.
REQ-018 Ack and timeout on same cycle: ack wins (gnt_o, no err_o).
REQ-019 GAP: exactly one cycle; wbm_ack_i ignored (absorbs the slave's trailing registered ack); then IDLE.
REQ-020 On leaving BUS (ack or timeout), ptr = winner + 1 mod 4.
REQ-021 req_i sampled only in IDLE; req_i or req_dat_i changes during BUS/GAP have no effect on the current transfer.
REQ-022 Requester dropping req_i mid-transfer: transfer completes, its gnt_o/err_o still pulses.
REQ-023 With slave ack latency 1, back-to-back requests issue one write per 4 cycles (IDLE, BUS, BUS, GAP).
REQ-024 wbm_dat_o and wbm_sel_o SHALL be 0 outside BUS.

Reset
REQ-025 rst_i assertion SHALL immediately force state IDLE, ptr = 0, counter = 0, all outputs 0, independent of clk_i.
REQ-026 Reset mid-BUS SHALL abort the cycle with no gnt_o or err_o pulse; first post-reset arbitration starts at requester 0.

Structure
REQ-027 State encoding, NREQ, and TIMEOUT default SHALL live in the shared hex_display package.
REQ-028 Round-robin selection SHALL be a sub-module hex_display_rr_pick (inputs req, ptr; outputs one-hot grant, index, any); FSM, counter, and Wishbone outputs stay in hex_display_arb.

Verification
REQ-029 Single request: req_i = 4'b0100, dat = 16'h1234, slave ack latency 1 -> stb high 1 cycle after sample, slave value = 16'h1234, gnt_o = 4'b0100 one cycle, busy_o low after GAP.
REQ-030 All four requesting continuously, ptr = 0 -> grant order 0,1,2,3,0; each gnt_o pulse 4 cycles apart.
REQ-031 Slave never acks, TIMEOUT = 15 -> 15 BUS cycles, err_o[winner] pulse, no gnt_o, ptr advanced.
REQ-032 Ack on the cycle the counter reaches TIMEOUT -> gnt_o pulse, err_o stays 0.
REQ-033 rst_i asserted in second BUS cycle -> cyc/stb drop before next clock edge, no gnt/err pulse, next grant to requester 0.
REQ-034 Trailing ack held high during GAP -> no second write, no extra gnt_o.
